// File: rtl/config_port_arbiter_pkg.sv
// Shared constants and the read-tracking tag type for the config port B arbiter.
package cfg_arb_pkg;

    localparam int unsigned DEF_N_REQ        = 4;
    localparam int unsigned DEF_ADDR_W       = 6;
    localparam int unsigned DEF_DATA_W       = 16;
    localparam int unsigned DEF_READ_LATENCY = 2;

    // The id field is sized for the largest supported requester count so the
    // tag type can live here, independent of any one instance's N_REQ.
    localparam int unsigned MAX_N_REQ = 8;
    localparam int unsigned TAG_ID_W  = $clog2(MAX_N_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/config_port_arbiter_if.sv
// Requester-side and BRAM port B signals of the config port arbiter.
interface config_port_arbiter_if
    import cfg_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DEF_N_REQ,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]             REQ;
    logic [N_REQ-1:0]             REQ_WE;
    logic [N_REQ-1:0][ADDR_W-1:0] REQ_ADDR;
    logic [N_REQ-1:0][DATA_W-1:0] REQ_DIN;
    logic [N_REQ-1:0]             GNT;
    logic [N_REQ-1:0]             RVALID;
    logic [DATA_W-1:0]            RDATA;
    logic [ADDR_W-1:0]            BRAM_ADDR;
    logic                         BRAM_WE;
    logic [DATA_W-1:0]            BRAM_DIN;
    logic [DATA_W-1:0]            BRAM_DOUT;

    // Arbiter side
    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_DIN, BRAM_DOUT,
        output GNT, RVALID, RDATA, BRAM_ADDR, BRAM_WE, BRAM_DIN
    );

    // Requesters plus BRAM side
    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_DIN, BRAM_DOUT,
        input  GNT, RVALID, RDATA, BRAM_ADDR, BRAM_WE, BRAM_DIN
    );

endinterface

// File: rtl/config_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker
    import cfg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned PTR_W = $clog2(DEF_N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    // Scan N_REQ positions starting at ptr; the first hit wins
    always_comb begin
        int unsigned cand;
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!valid && req[PTR_W'(cand)]) begin
                valid                = 1'b1;
                idx                  = PTR_W'(cand);
                pick[PTR_W'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Round-robin arbiter serializing single-word requester accesses onto BRAM
// port B, with a tag pipeline that routes read data back to its requester.
module config_port_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = DEF_N_REQ,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
)(
    input  logic                 CLK,
    input  logic                 RST_N,
    config_port_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    // One extra stage covers the issue register in front of the BRAM.
    localparam int unsigned DEPTH = READ_LATENCY + 1;

    logic [PTR_W-1:0]        rr_ptr;
    logic [N_REQ-1:0]        eligible;
    logic [N_REQ-1:0]        pick;
    logic                    pick_valid;
    logic [PTR_W-1:0]        pick_idx;
    logic [ADDR_W-1:0]       sel_addr;
    logic                    sel_we;
    logic [DATA_W-1:0]       sel_din;
    tag_t                    new_tag;
    tag_t [DEPTH-1:0]        tags;
    logic [N_REQ-1:0]        rvalid_next;

    // A requester currently seeing its grant is masked so a held request
    // is not granted twice.
    assign eligible = bus.REQ & ~bus.GNT;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (eligible),
        .ptr   (rr_ptr),
        .pick  (pick),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Mux the winning requester's access fields and build its tag
    always_comb begin
        sel_addr      = bus.REQ_ADDR[pick_idx];
        sel_we        = bus.REQ_WE[pick_idx];
        sel_din       = sel_we ? bus.REQ_DIN[pick_idx] : '0;
        new_tag       = '0;
        new_tag.valid = pick_valid & ~sel_we;
        new_tag.id    = TAG_ID_W'(pick_idx);
    end

    // Decode the tag leaving the pipeline into a one-hot read-valid
    always_comb begin
        rvalid_next = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rvalid_next[i] = tags[DEPTH-1].valid && (tags[DEPTH-1].id == TAG_ID_W'(i));
        end
    end

    // Grant issue: register grant, BRAM command and advance rr_ptr
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.GNT       <= '0;
            bus.BRAM_ADDR <= '0;
            bus.BRAM_WE   <= 1'b0;
            bus.BRAM_DIN  <= '0;
            rr_ptr        <= '0;
        end else begin
            bus.GNT <= pick;
            if (pick_valid) begin
                bus.BRAM_ADDR <= sel_addr;
                bus.BRAM_WE   <= sel_we;
                bus.BRAM_DIN  <= sel_din;
                rr_ptr        <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                bus.BRAM_WE <= 1'b0;
            end
        end
    end

    // Tag shift register tracking each access through the BRAM latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tags <= '0;
        end else begin
            tags <= {tags[DEPTH-2:0], new_tag};
        end
    end

    // Read return: capture BRAM data when a read tag exits the pipeline
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.RVALID <= '0;
            bus.RDATA  <= '0;
        end else begin
            bus.RVALID <= rvalid_next;
            if (tags[DEPTH-1].valid) begin
                bus.RDATA <= bus.BRAM_DOUT;
            end
        end
    end

endmodule
